vector_mem_unit: RTL
====================

Name: vector_mem_unit

Overview:
- MEM-stage sequencer between the EX/MEM pipeline register and a narrow 16-bit data RAM.
- Splits each 48-bit vector store into 3 beats and gathers each vector load from 3 beats.
- Holds the upstream pipeline with `stall` until the access retires.
- Scalar datapath is untouched; only vector memory traffic passes through this block.

Parameters:
- ADDR_W, 32, address width of request and RAM port (beat-addressed, 16-bit words).
- VEC_W, 48, vector width (three 16-bit lanes).
- BEAT_W, 16, RAM data width; BEATS = VEC_W/BEAT_W (=3) is a derived localparam.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  vector memory op present in EX/MEM register.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  base beat address.
- req_wdata  in  VEC_W  store data; lane i = bits [16i+15:16i].
- req_ready  out  1  high only in IDLE.
- stall  out  1  freeze fetch through EX/MEM.
- rsp_valid  out  1  one-cycle pulse, load data valid.
- rsp_rdata  out  VEC_W  gathered load vector.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  BEAT_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_rden  out  1  RAM read enable.
- mem_q  in  BEAT_W  RAM read data, valid 1 cycle after mem_rden.

Behaviour:
- Reset (async, rst=0): state IDLE, beat counters 0, latched addr/data 0.
  - All outputs 0 except req_ready=1.
  - Reset mid-access aborts it; beats already written stay in RAM; no rsp_valid.
- States: IDLE, WBEAT, RBEAT, RDRAIN, RESP.
- IDLE: accepts when req_valid=1.
  - Latches addr/wdata; stall=1 combinationally in the accept cycle t.
  - Next state: WBEAT if req_we=1, else RBEAT.
- WBEAT (t+1..t+3), beat b=0..2:
  - mem_wren=1, mem_addr=base+b, mem_wdata=lane b.
  - stall=1 for b<2; stall=0 at b=2 so the request retires.
  - Then IDLE; no rsp_valid for stores.
- RBEAT (t+1..t+3): mem_rden=1, mem_addr=base+b; stall=1.
- Lane capture: mem_q is written into lane b at the edge ending cycle t+2+b, including the drain cycle.
- RDRAIN (t+4): last capture; stall=1; mem_rden=0.
- RESP (t+5): rsp_valid=1, rsp_rdata holds the gathered vector, stall=0; then IDLE.
- rsp_rdata holds its value until the next load completes.
- Store occupancy 4 cycles (stall high 3); load occupancy 6 cycles (stall high 5).
- Address arithmetic is modulo 2^ADDR_W: base 0xFFFF_FFFF wraps to 0x0, then 0x1.
- Stall drops in the retire cycle, so a request still present on return to IDLE is a new one and is accepted immediately. There are no idle bubbles.
- req_valid is ignored outside IDLE; req inputs may change while stalled without effect.
- mem_wren and mem_rden are never both 1.

Optional Feature:
- Macro VECTOR_MEM_UNIT_PERF_EN.
- When defined, adds outputs perf_reqs[31:0] (accepted requests) and perf_stall[31:0] (cycles with stall=1).
  - Both reset to 0 and saturate at 0xFFFF_FFFF.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package vmu_pkg holds:
  - state enum vmu_state_t;
  - VEC_W, BEAT_W, BEATS constants;
  - the lane-select function (vector, index) -> beat.
- Sub-module vmu_lane_gather: registered 3-lane assembler with lane index and capture enable.
  - Reused later for vector DMA.

Test Plan:
- Reset: rst low with req_valid=1 -> req_ready=1, stall=0, mem_wren=mem_rden=0, rsp_valid=0.
- Store 0x0003_0002_0001 to addr 0x10 -> mem_wren on 3 consecutive cycles writing 0x0001@0x10, 0x0002@0x11, 0x0003@0x12. Stall high 3 cycles, no rsp_valid.
- Load from 0x10 after that store -> rsp_valid pulse at t+5 with rsp_rdata=0x0003_0002_0001. Stall high t..t+4.
- Back-to-back store then load with req_valid held continuously -> load accepted the cycle after the store's last beat, with no idle cycle.
- Wrap: store to 0xFFFF_FFFF -> beats at 0xFFFF_FFFF, 0x0, 0x1.
- Reset asserted during RBEAT beat 1 -> outputs return to reset values immediately; no rsp_valid after release. The next load completes normally.

Source files
------------

// File: rtl/vmu_pkg.sv
// Shared types and constants for the vector memory unit.
// Holds the FSM state enum, lane geometry and the lane-select helper.
package vmu_pkg;

    localparam int VEC_W  = 48;
    localparam int BEAT_W = 16;
    localparam int BEATS  = VEC_W / BEAT_W;
    localparam int IDX_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WBEAT,
        S_RBEAT,
        S_RDRAIN,
        S_RESP
    } vmu_state_t;

    // Pick 16-bit lane idx out of a vector (lane 0 in the low bits).
    function automatic logic [BEAT_W-1:0] lane_sel(
        input logic [VEC_W-1:0] vec,
        input logic [IDX_W-1:0] idx
    );
        logic [VEC_W-1:0] sh;
        sh = vec >> (BEAT_W * int'(idx));
        return sh[BEAT_W-1:0];
    endfunction

endpackage

// File: rtl/vector_mem_unit_lane_gather.sv
// vmu_lane_gather: registered multi-lane assembler.
// Ports: clk, rst (async active-low), cap_en/cap_idx/cap_data in, vec out.
module vmu_lane_gather
    import vmu_pkg::*;
#(
    parameter int LANE_W = 16,
    parameter int LANES  = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap_en,
    input  logic [SEL_W-1:0]        cap_idx,
    input  logic [LANE_W-1:0]       cap_data,
    output logic [LANES*LANE_W-1:0] vec
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vec <= '0;
        end else if (cap_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (cap_idx == SEL_W'(i)) begin
                    vec[i*LANE_W +: LANE_W] <= cap_data;
                end
            end
        end
    end

endmodule

// File: rtl/vector_mem_unit.sv
// vector_mem_unit: MEM-stage sequencer splitting 48-bit vector accesses
// into three 16-bit RAM beats, stalling the pipeline until retirement.
// Ports: clk, rst (async active-low); req_* from EX/MEM, req_ready, stall;
// rsp_valid/rsp_rdata load result; mem_* narrow RAM port, mem_q read data.
// Optional macro VECTOR_MEM_UNIT_PERF_EN adds perf_reqs/perf_stall counters.
module vector_mem_unit #(
    parameter int ADDR_W = 32,
    parameter int VEC_W  = vmu_pkg::VEC_W,
    parameter int BEAT_W = vmu_pkg::BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [VEC_W-1:0]  req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic [VEC_W-1:0]  rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [BEAT_W-1:0] mem_q
`ifdef VECTOR_MEM_UNIT_PERF_EN
    ,
    output logic [31:0]       perf_reqs,
    output logic [31:0]       perf_stall
`endif
);

    import vmu_pkg::*;

    localparam int BEATS = VEC_W / BEAT_W;
    localparam logic [1:0] LAST = 2'(BEATS - 1);

    vmu_state_t        state;
    logic [1:0]        beat;
    logic [ADDR_W-1:0] base_q;
    logic [VEC_W-1:0]  wdata_q;
    logic [VEC_W-1:0]  rsp_q;
    logic [VEC_W-1:0]  gvec;
    logic [ADDR_W-1:0] beat_addr;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic              accept;

    assign accept    = (state == S_IDLE) && req_valid;
    assign beat_addr = base_q + ADDR_W'(beat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            beat    <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        base_q  <= req_addr;
                        wdata_q <= req_wdata;
                        beat    <= '0;
                        state   <= req_we ? S_WBEAT : S_RBEAT;
                    end
                end
                S_WBEAT: begin
                    if (beat == LAST) begin
                        beat  <= '0;
                        state <= S_IDLE;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                S_RBEAT: begin
                    if (beat == LAST) begin
                        beat  <= '0;
                        state <= S_RDRAIN;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                S_RDRAIN: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    // Keep the result visible while the gather
                    // register fills with the next load.
                    rsp_q <= gvec;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read data trails mem_rden by one cycle, so lane b lands one
    // cycle after its beat; the final lane lands in the drain cycle.
    always_comb begin
        cap_en  = 1'b0;
        cap_idx = '0;
        if (state == S_RBEAT && beat != 2'd0) begin
            cap_en  = 1'b1;
            cap_idx = beat - 2'd1;
        end else if (state == S_RDRAIN) begin
            cap_en  = 1'b1;
            cap_idx = LAST;
        end
    end

    vmu_lane_gather #(
        .LANE_W (BEAT_W),
        .LANES  (BEATS),
        .SEL_W  (2)
    ) u_gather (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (cap_en),
        .cap_idx  (cap_idx),
        .cap_data (mem_q),
        .vec      (gvec)
    );

    always_comb begin
        req_ready = 1'b0;
        stall     = 1'b0;
        rsp_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        mem_rden  = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                // Accept cycle stalls at once; held low during reset.
                stall     = req_valid & rst;
            end
            S_WBEAT: begin
                mem_wren  = 1'b1;
                mem_addr  = beat_addr;
                mem_wdata = lane_sel(wdata_q, beat);
                stall     = (beat != LAST);
            end
            S_RBEAT: begin
                mem_rden = 1'b1;
                mem_addr = beat_addr;
                stall    = 1'b1;
            end
            S_RDRAIN: begin
                stall = 1'b1;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rsp_rdata = (state == S_RESP) ? gvec : rsp_q;

`ifdef VECTOR_MEM_UNIT_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_reqs  <= '0;
            perf_stall <= '0;
        end else begin
            if (accept && perf_reqs != 32'hFFFF_FFFF) begin
                perf_reqs <= perf_reqs + 32'd1;
            end
            if (stall && perf_stall != 32'hFFFF_FFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
